// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the 2048x32 data memory.
// m0 = CPU load/store unit, m1 = debug/DMA port. One access in flight at a time;
// round-robin on contention, one-cycle done (and err) pulse per request.
module dmem_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [1:0]        m0_type_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_done_o,
  output logic              m0_err_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [1:0]        m1_type_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_done_o,
  output logic              m1_err_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              dm_ena_o,
  output logic              dm_wena_o,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [1:0]        dm_type_o,
  output logic [DATA_W-1:0] dm_data_o,
  input  logic [DATA_W-1:0] dm_data_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        typ;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_t                  state_q, state_d;
  cmd_t   [1:0]            cmd_in;
  cmd_t                    cmd_q;
  logic   [1:0]            req;
  logic   [1:0][DATA_W-1:0] rdata_q;
  logic   [1:0]            done;
  logic                    gnt;
  logic                    win_q;
  logic                    rr_q;
  logic                    err_q;

  assign req       = {m1_req_i, m0_req_i};
  assign cmd_in[0] = {m0_we_i, m0_addr_i, m0_type_i, m0_wdata_i};
  assign cmd_in[1] = {m1_we_i, m1_addr_i, m1_type_i, m1_wdata_i};

  // Sole requester wins outright; under contention rr_q picks
  assign gnt = (&req) ? rr_q : req[1];

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state: illegal type skips the memory entirely; writes skip WAIT
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = (cmd_in[gnt].typ == 2'b11) ? DONE : ACCESS;
      ACCESS:  state_d = cmd_q.we ? DONE : WAIT;
      WAIT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant: latch the winner's command and hand priority to the loser
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cmd_q <= '0;
      win_q <= 1'b0;
      rr_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (state_q == IDLE && |req) begin
      cmd_q <= cmd_in[gnt];
      win_q <= gnt;
      rr_q  <= ~gnt;
      err_q <= (cmd_in[gnt].typ == 2'b11);
    end
  end

  // Read return: only the winner's register is updated
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)              rdata_q <= '0;
    else if (state_q == WAIT)  rdata_q[win_q] <= dm_data_i;
  end

  assign done       = (state_q == DONE) ? (2'b01 << win_q) : 2'b00;
  assign m0_done_o  = done[0];
  assign m1_done_o  = done[1];
  assign m0_err_o   = done[0] & err_q;
  assign m1_err_o   = done[1] & err_q;
  assign m0_rdata_o = rdata_q[0];
  assign m1_rdata_o = rdata_q[1];

  // Memory strobes only in ACCESS; address/type/data always show the latched command
  assign dm_ena_o   = (state_q == ACCESS);
  assign dm_wena_o  = (state_q == ACCESS) & cmd_q.we;
  assign dm_addr_o  = cmd_q.addr;
  assign dm_type_o  = cmd_q.typ;
  assign dm_data_o  = cmd_q.wdata;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 2048x32 memory.
module tb_dmem_arbiter;

  logic clk = 0;
  logic rst_n = 0;
  logic [1:0]       req = '0, we = '0;
  logic [1:0][10:0] addr = '0;
  logic [1:0][1:0]  typ = '0;
  logic [1:0][31:0] wdata = '0;
  logic             m0_done, m0_err, m1_done, m1_err;
  logic [31:0]      m0_rdata, m1_rdata;
  logic             dm_ena, dm_wena, busy;
  logic [10:0]      dm_addr;
  logic [1:0]       dm_type;
  logic [31:0]      dm_wdat, dm_rdat = '0;

  dmem_arbiter #(.ADDR_W(11), .DATA_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_addr_i(addr[0]), .m0_type_i(typ[0]),
    .m0_wdata_i(wdata[0]), .m0_done_o(m0_done), .m0_err_o(m0_err), .m0_rdata_o(m0_rdata),
    .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_addr_i(addr[1]), .m1_type_i(typ[1]),
    .m1_wdata_i(wdata[1]), .m1_done_o(m1_done), .m1_err_o(m1_err), .m1_rdata_o(m1_rdata),
    .dm_ena_o(dm_ena), .dm_wena_o(dm_wena), .dm_addr_o(dm_addr), .dm_type_o(dm_type),
    .dm_data_o(dm_wdat), .dm_data_i(dm_rdat), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Memory model: sub-word writes touch only the low bits, registered read port
  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (dm_ena) begin
      if (dm_wena) begin
        case (dm_type)
          2'b00: mem[dm_addr] <= dm_wdat;
          2'b01: mem[dm_addr][15:0] <= dm_wdat[15:0];
          2'b10: mem[dm_addr][7:0] <= dm_wdat[7:0];
          default: ;
        endcase
      end else begin
        dm_rdat <= mem[dm_addr];
      end
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic        err;
    logic        rd;
    logic [31:0] data;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] last_rd [2] = '{32'h0, 32'h0};
  logic [1:0]  dn, er;
  logic [1:0][31:0] rdv;
  assign dn  = {m1_done, m0_done};
  assign er  = {m1_err, m0_err};
  assign rdv = {m1_rdata, m0_rdata};

  // Completion monitor: pop the scoreboard on every done pulse
  always @(negedge clk) begin
    if (rst_n && |dn) begin
      chk("both_done", {31'b0, &dn}, 32'd0);
      for (int i = 0; i < 2; i++) begin
        if (dn[i]) begin
          if (sb.size() == 0) chk("sb_nonempty", 32'd0, 32'd1);
          else begin
            exp_t e;
            e = sb.pop_front();
            chk("grant_id", i, e.id);
            chk("err", {31'b0, er[i]}, {31'b0, e.err});
            if (e.rd) last_rd[i] = e.data;
            chk("rdata", rdv[i], last_rd[i]);
            chk("other_rdata", rdv[1-i], last_rd[1-i]);
          end
        end
      end
    end
  end

  logic [1:0] last_type;

  // One request on its own; checks latency, strobes and busy
  task automatic xact(input int id, input logic w, input logic [10:0] a, input logic [1:0] t,
                      input logic [31:0] d, input logic [31:0] exp_rd, input int exp_cyc,
                      input logic [10:0] a2, input string tag);
    int cyc = 0, ena_n = 0;
    logic seen = 0;
    logic ill = (t == 2'b11);
    sb.push_back('{id, ill, !w && !ill, exp_rd});
    we[id] = w; addr[id] = a; typ[id] = t; wdata[id] = d; req[id] = 1;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
      if (dm_ena) begin
        ena_n++;
        last_type = dm_type;
        chk({tag, "_wena"}, {31'b0, dm_wena}, {31'b0, w});
        chk({tag, "_addr"}, {21'b0, dm_addr}, {21'b0, a});
        if (w) chk({tag, "_wdata"}, dm_wdat, d);
      end
      if (cyc == 1) addr[id] = a2;
      seen = dn[id];
    end
    chk({tag, "_latency"}, cyc, exp_cyc);
    chk({tag, "_ena_cnt"}, ena_n, ill ? 0 : 1);
    req[id] = 0;
    @(negedge clk);
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  // Run with requests already asserted until n dones; drop each req on its done unless held
  task automatic run(input int n, input bit hold, input string tag);
    int got = 0, cyc = 0;
    while (got < n && cyc < 20 * n) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++)
        if (dn[i]) begin
          got++;
          if (!hold) req[i] = 0;
        end
    end
    chk({tag, "_dones"}, got, n);
    req = '0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    sb.delete();
    last_rd[0] = 0; last_rd[1] = 0;
    req = '0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ena", {30'b0, dm_ena, dm_wena}, 32'd0);
    chk("rst_done", {28'b0, dn, er}, 32'd0);
    chk("rst_rdata0", m0_rdata, 32'd0);
    chk("rst_rdata1", m1_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Word write then read back
    xact(0, 1, 11'h005, 2'b00, 32'hDEADBEEF, 32'h0, 2, 11'h005, "wr0");
    xact(0, 0, 11'h005, 2'b00, 32'h0, 32'hDEADBEEF, 3, 11'h005, "rd0");

    // Sub-word writes
    xact(0, 1, 11'h007, 2'b00, 32'h11223344, 32'h0, 2, 11'h007, "pre7");
    xact(1, 1, 11'h007, 2'b01, 32'hAAAA5566, 32'h0, 2, 11'h007, "half");
    chk("half_type", {30'b0, last_type}, 32'd1);
    xact(1, 0, 11'h007, 2'b00, 32'h0, 32'h11225566, 3, 11'h007, "rdh");
    xact(1, 1, 11'h007, 2'b10, 32'h000000FF, 32'h0, 2, 11'h007, "byte");
    chk("byte_type", {30'b0, last_type}, 32'd2);
    xact(1, 0, 11'h007, 2'b00, 32'h0, 32'h112255FF, 3, 11'h007, "rdb");

    // Illegal type: immediate done+err, memory untouched, rdata held
    xact(1, 0, 11'h007, 2'b11, 32'h0, 32'h0, 1, 11'h007, "ill");

    // Command stability: address changes during ACCESS
    xact(0, 0, 11'h005, 2'b00, 32'h0, 32'hDEADBEEF, 3, 11'h007, "stab");

    // Contention from reset: alternate m0,m1,m0,m1
    do_reset();
    sb.push_back('{0, 1'b0, 1'b1, 32'hDEADBEEF});
    sb.push_back('{1, 1'b0, 1'b1, 32'h112255FF});
    sb.push_back('{0, 1'b0, 1'b1, 32'hDEADBEEF});
    sb.push_back('{1, 1'b0, 1'b1, 32'h112255FF});
    we = '0; typ = '0; addr[0] = 11'h005; addr[1] = 11'h007; req = 2'b11;
    run(4, 1, "cont");
    chk("cont_sb_empty", sb.size(), 0);

    // Reset in WAIT aborts the read
    sb.push_back('{0, 1'b0, 1'b1, 32'hDEADBEEF});
    we[0] = 0; typ[0] = 0; addr[0] = 11'h005; req[0] = 1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_rst_ena", {31'b0, dm_ena}, 32'd0);
    chk("mid_rst_done", {30'b0, dn}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_rdata", m0_rdata, 32'd0);
    sb.delete();
    last_rd[0] = 0; last_rd[1] = 0;
    req = '0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Fresh contention after reset: m0 must be served first
    sb.push_back('{0, 1'b0, 1'b1, 32'hDEADBEEF});
    sb.push_back('{1, 1'b0, 1'b1, 32'h112255FF});
    req = 2'b11;
    run(2, 0, "post_rst");
    chk("post_rst_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
